// File: rtl/dds_disp_pkg.sv
// Shared constants and types for the DDS frequency display path.
// Used by the binary-to-BCD converter and the display scanner.
package dds_disp_pkg;

  localparam int DISP_DIGITS = 8;
  localparam int DISP_BIN_W  = 28;

  localparam int unsigned  DISP_MAX     = 32'd99_999_999;
  localparam logic [31:0]  DISP_SAT_BCD = 32'h9999_9999;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic logic [63:0] bcd_max_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  // Conditional +3 correction.
  always_comb begin
    if (digit >= 4'd5) begin
      digit_adj = digit + 4'd3;
    end else begin
      digit_adj = digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Out-of-range values saturate the display to all nines and raise overflow.
module bin_to_bcd8
  import dds_disp_pkg::*;
#(
  parameter int BIN_W  = DISP_BIN_W,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*4-1:0] bcd,
  output logic                overflow
);

  localparam int                BCD_W    = DIGITS * 4;
  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [63:0]       MAX_VAL  = bcd_max_value(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
  localparam logic [BCD_W-1:0]  SAT_BCD  = {DIGITS{4'h9}};

  b2b_state_t        state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic [BIN_W-1:0]  shreg_r, shreg_nx;
  logic [BCD_W-1:0]  scratch_r, scratch_nx;
  logic              ovf_flag_r, ovf_flag_nx;
  logic [BCD_W-1:0]  bcd_nx;
  logic              overflow_nx;
  logic              done_nx;
  logic              busy_nx;

  logic [BCD_W-1:0]  scratch_adj_s;
  logic [BCD_W-1:0]  scratch_shift_s;
  logic              over_range_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (scratch_r[g*4 +: 4]),
      .digit_adj (scratch_adj_s[g*4 +: 4])
    );
  end

  // Top scratch bit falls off here; saturation hides the loss for large inputs.
  assign scratch_shift_s = {scratch_adj_s[BCD_W-2:0], shreg_r[BIN_W-1]};
  assign over_range_s    = (64'(bin) > MAX_VAL);

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    shreg_nx    = shreg_r;
    scratch_nx  = scratch_r;
    ovf_flag_nx = ovf_flag_r;
    bcd_nx      = bcd;
    overflow_nx = overflow;
    done_nx     = 1'b0;
    busy_nx     = busy;
    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_nx    = bin;
          scratch_nx  = '0;
          cnt_nx      = CNT_LOAD;
          ovf_flag_nx = over_range_s;
          busy_nx     = 1'b1;
          state_nx    = SHIFT;
        end else begin
          state_nx    = IDLE;
        end
      end
      SHIFT: begin
        scratch_nx = scratch_shift_s;
        shreg_nx   = {shreg_r[BIN_W-2:0], 1'b0};
        cnt_nx     = cnt_r - CNT_LAST;
        if (cnt_r == CNT_LAST) begin
          bcd_nx      = ovf_flag_r ? SAT_BCD : scratch_shift_s;
          overflow_nx = ovf_flag_r;
          done_nx     = 1'b1;
          busy_nx     = 1'b0;
          state_nx    = IDLE;
        end else begin
          state_nx    = SHIFT;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      shreg_r    <= '0;
      scratch_r  <= '0;
      ovf_flag_r <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      shreg_r    <= shreg_nx;
      scratch_r  <= scratch_nx;
      ovf_flag_r <= ovf_flag_nx;
      bcd        <= bcd_nx;
      overflow   <= overflow_nx;
      done       <= done_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Self-checking bench for bin_to_bcd8: directed cases with literal results
// plus randomized conversions checked every cycle against a decimal model.
module tb_bin_to_bcd8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [27:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  bin_to_bcd8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by plain division, saturated above eight digits.
  function automatic logic [31:0] to_bcd(input logic [27:0] val);
    int unsigned v;
    logic [31:0] r;
    v = val;
    r = 32'h0;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion takes 28 cycles and then publishes the decimal value.
  int          m_left;
  logic [27:0] m_val;
  logic        m_busy, m_done, m_ovf;
  logic [31:0] m_bcd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_val <= 28'd0; m_busy <= 1'b0; m_done <= 1'b0;
      m_ovf <= 1'b0; m_bcd <= 32'h0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= 28; m_val <= bin; m_busy <= 1'b1;
        end
      end else if (m_left == 1) begin
        m_left <= 0; m_busy <= 1'b0; m_done <= 1'b1;
        m_bcd  <= to_bcd(m_val);
        m_ovf  <= (m_val > 28'd99_999_999);
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("bcd", bcd, m_bcd);
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic pulse(input logic [27:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 28'($urandom);
  endtask

  // Waits for done (bounded) and counts cycles busy was seen high.
  task automatic wait_done(output int busy_cnt);
    int t;
    busy_cnt = 0;
    t = 0;
    while (done !== 1'b1 && t < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      n_checks++;
      n_errs++;
      $display("FAIL wait_done: timeout got done=%b expected 1", done);
    end
  endtask

  task automatic conv(input string name, input logic [27:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    int bc;
    pulse(v);
    wait_done(bc);
    check({name, "_bcd"}, bcd, exp_bcd);
    check({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({name, "_busy_len"}, 32'(bc), 32'd28);
  endtask

  initial begin
    int bc, gap, n_done;
    logic [27:0] v;
    rst_n = 1'b0; start = 1'b0; bin = 28'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", bcd, 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    conv("c12345678", 28'd12_345_678, 32'h1234_5678, 1'b0);
    conv("c0", 28'd0, 32'h0000_0000, 1'b0);
    conv("c99999999", 28'd99_999_999, 32'h9999_9999, 1'b0);
    conv("c100000000", 28'd100_000_000, 32'h9999_9999, 1'b1);
    conv("cmax", 28'd268_435_455, 32'h9999_9999, 1'b1);
    conv("c5", 28'd5, 32'h0000_0005, 1'b0);

    // start during SHIFT is ignored
    pulse(28'd42);
    repeat (9) @(negedge clk);
    start = 1'b1; bin = 28'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("ignore_bcd", bcd, 32'h0000_0042);
    n_done = 0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("ignore_no_second_done", 32'(n_done), 32'd0);

    // reset mid-conversion
    pulse(28'd87_654_321);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bcd", bcd, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    conv("c87654321", 28'd87_654_321, 32'h8765_4321, 1'b0);

    // start held high: one completion every 29 cycles
    @(negedge clk);
    start = 1'b1; bin = 28'd1_000_000;
    @(negedge clk);
    wait_done(bc);
    check("held_bcd0", bcd, 32'h0100_0000);
    for (int k = 0; k < 2; k++) begin
      bc = 0;
      @(negedge clk);
      bc++;
      while (done !== 1'b1 && bc < 60) begin
        @(negedge clk);
        bc++;
      end
      check("held_period", 32'(bc), 32'd29);
      check("held_bcd", bcd, 32'h0100_0000);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);

    // randomized conversions with stray starts while busy
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: v = 28'($urandom_range(0, 999));
        1: v = 28'($urandom_range(99_999_990, 100_000_010));
        default: v = 28'($urandom);
      endcase
      pulse(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        start = 1'b1; bin = 28'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(bc);
      check("rand_bcd", bcd, to_bcd(v));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
